// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for decode_stage.
// The slave modport is the decode stage; the master modport is the fetch/execute side.
interface decode_stage_if #(
   parameter int EXEC_MASK_W = 64,
   parameter int ADDR_W      = 64
);
   logic                   in_valid;
   logic                   in_busy;
   logic [EXEC_MASK_W-1:0] in_exec_mask;
   logic [ADDR_W-1:0]      in_pc;
   logic [31:0]            in_insn;

   logic                   out_valid;
   logic                   out_ready;
   logic [EXEC_MASK_W-1:0] out_exec_mask;
   logic [ADDR_W-1:0]      out_pc;
   logic [7:0]             out_opcode;
   logic [4:0]             out_dst;
   logic [4:0]             out_src1;
   logic [4:0]             out_src2;
   logic [63:0]            out_imm;
   logic                   out_is_cf;
   logic                   out_illegal;

   modport master (
      output in_valid, in_exec_mask, in_pc, in_insn, out_ready,
      input  in_busy, out_valid, out_exec_mask, out_pc, out_opcode, out_dst,
             out_src1, out_src2, out_imm, out_is_cf, out_illegal
   );

   modport slave (
      input  in_valid, in_exec_mask, in_pc, in_insn, out_ready,
      output in_busy, out_valid, out_exec_mask, out_pc, out_opcode, out_dst,
             out_src1, out_src2, out_imm, out_is_cf, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: field split + classification into a 2-entry FIFO toward execute.
// Optional statistics counters are built only when DECODE_STATS_EN is defined.
module decode_stage #(
   parameter int         EXEC_MASK_W = 64,
   parameter int         ADDR_W      = 64,
   parameter logic [7:0] MAX_OPCODE  = 8'h30
) (
   input  logic                 clk,
   input  logic                 rst,
   decode_stage_if.slave        bus,
   input  logic                 flush,
   output logic                 halted,
   output logic [31:0]          stat_decoded,
   output logic [31:0]          stat_stall,
   output logic                 fsm_state
);
   // Handshake: input transfers at an edge where in_valid && !in_busy (in_busy is a
   // register, never a combinational function of out_ready); output transfers at an
   // edge where out_valid && out_ready. flush beats both, rst beats flush.

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   typedef struct packed {
      logic [EXEC_MASK_W-1:0] exec_mask;
      logic [ADDR_W-1:0]      pc;
      logic [7:0]             opcode;
      logic [4:0]             dst;
      logic [4:0]             src1;
      logic [4:0]             src2;
      logic [63:0]            imm;
      logic                   is_cf;
      logic                   illegal;
   } entry_t;

   state_t           state, state_n;
   entry_t [1:0]     mem, mem_n;
   entry_t           dec, head;
   logic             wr_ptr, rd_ptr, wr_n, rd_n;
   logic [1:0]       cnt, cnt_n;
   logic             busy, push, pop;

   always_comb begin
      dec           = '0;
      dec.exec_mask = bus.in_exec_mask;
      dec.pc        = bus.in_pc;
      dec.opcode    = bus.in_insn[7:0];
      dec.dst       = bus.in_insn[12:8];
      dec.src1      = bus.in_insn[17:13];
      dec.src2      = bus.in_insn[22:18];
      dec.imm       = {{50{bus.in_insn[31]}}, bus.in_insn[31:18]};
      dec.is_cf     = (dec.opcode == 8'h00) ||
                      (dec.opcode >= 8'h10 && dec.opcode <= 8'h16) ||
                      (dec.opcode == 8'h20);
      dec.illegal   = dec.opcode > MAX_OPCODE;
   end

   assign push = bus.in_valid && !busy;
   assign pop  = (cnt != 2'd0) && bus.out_ready;

   always_comb begin
      mem_n   = mem;
      wr_n    = wr_ptr;
      rd_n    = rd_ptr;
      cnt_n   = cnt;
      state_n = state;
      if (flush) begin
         cnt_n = 2'd0;
         wr_n  = 1'b0;
         rd_n  = 1'b0;
      end else begin
         if (push) begin
            mem_n[wr_ptr] = dec;
            wr_n          = ~wr_ptr;
         end
         if (pop) rd_n = ~rd_ptr;
         cnt_n = cnt + 2'(push) - 2'(pop);
         // The HALT packet itself is enqueued; only later packets are refused.
         if (state == RUN && push && dec.opcode == 8'h00) state_n = HALTED;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         cnt    <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         busy   <= 1'b1;
         mem    <= '0;
         head   <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         wr_ptr <= wr_n;
         rd_ptr <= rd_n;
         busy   <= (cnt_n == 2'd2) || (state_n == HALTED);
         mem    <= mem_n;
         // Output fields hold their last value whenever the FIFO goes empty.
         if (cnt_n != 2'd0) head <= mem_n[rd_n];
      end
   end

   assign bus.in_busy       = busy;
   assign bus.out_valid     = cnt != 2'd0;
   assign bus.out_exec_mask = head.exec_mask;
   assign bus.out_pc        = head.pc;
   assign bus.out_opcode    = head.opcode;
   assign bus.out_dst       = head.dst;
   assign bus.out_src1      = head.src1;
   assign bus.out_src2      = head.src2;
   assign bus.out_imm       = head.imm;
   assign bus.out_is_cf     = head.is_cf;
   assign bus.out_illegal   = head.illegal;
   assign halted            = state == HALTED;
   assign fsm_state         = state;

`ifdef DECODE_STATS_EN
   logic [31:0] decoded_q, stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         decoded_q <= '0;
         stall_q   <= '0;
      end else begin
         if (push && !flush) decoded_q <= decoded_q + 32'd1;
         if (bus.out_valid && !bus.out_ready) stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_decoded = decoded_q;
   assign stat_stall   = stall_q;
`else
   assign stat_decoded = '0;
   assign stat_stall   = '0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scenario tasks plus a negedge scoreboard
// that predicts every packet leaving the FIFO.
module tb_decode_stage;
   localparam int EW = 64;
   localparam int AW = 64;
   localparam int PW = EW + AW + 8 + 15 + 64 + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        halted, fsm_state;
   logic [31:0] stat_decoded, stat_stall;

   decode_stage_if #(.EXEC_MASK_W(EW), .ADDR_W(AW)) bus ();

   decode_stage #(.EXEC_MASK_W(EW), .ADDR_W(AW), .MAX_OPCODE(8'h30)) dut (
      .clk(clk), .rst(rst), .bus(bus), .flush(flush), .halted(halted),
      .stat_decoded(stat_decoded), .stat_stall(stat_stall), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [PW-1:0] exp_q[$];
   logic [31:0] exp_decoded = '0;
   logic [31:0] exp_stall = '0;

   function automatic logic [PW-1:0] exp_pkt(input logic [EW-1:0] mask,
                                             input logic [AW-1:0] pc,
                                             input logic [31:0] insn);
      logic [7:0] op;
      logic       cf, ill;
      op  = insn[7:0];
      cf  = (op == 8'h00) || (op >= 8'h10 && op <= 8'h16) || (op == 8'h20);
      ill = op > 8'h30;
      return {mask, pc, op, insn[12:8], insn[17:13], insn[22:18],
              {{50{insn[31]}}, insn[31:18]}, cf, ill};
   endfunction

   // Scoreboard: decide at negedge what the coming posedge will transfer.
   always @(negedge clk) begin
      logic [PW-1:0] exp, act;
      if (rst) begin
         exp_q.delete();
         exp_decoded = '0;
         exp_stall = '0;
      end else begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) exp_stall++;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
               n_checks++;
               act = {bus.out_exec_mask, bus.out_pc, bus.out_opcode, bus.out_dst,
                      bus.out_src1, bus.out_src2, bus.out_imm, bus.out_is_cf,
                      bus.out_illegal};
               if (exp_q.size() == 0) begin
                  $display("FAIL sb_unexpected: got pc %h op %h, expected no output",
                           bus.out_pc, bus.out_opcode);
               end else begin
                  exp = exp_q.pop_front();
                  if (act !== exp) $display("FAIL sb_packet: got %h exp %h", act, exp);
                  else n_pass++;
               end
            end
            if (bus.in_valid === 1'b1 && bus.in_busy === 1'b0) begin
               exp_q.push_back(exp_pkt(bus.in_exec_mask, bus.in_pc, bus.in_insn));
               exp_decoded++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pkt(input logic [AW-1:0] pc, input logic [7:0] op);
      logic [31:0] insn;
      insn = $urandom();
      insn[7:0] = op;
      bus.in_valid     = 1'b1;
      bus.in_pc        = pc;
      bus.in_exec_mask = {$urandom(), $urandom()};
      bus.in_insn      = insn;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic check_stats(input string name);
      logic [31:0] e_dec, e_stall;
`ifdef DECODE_STATS_EN
      e_dec = exp_decoded;
      e_stall = exp_stall;
`else
      e_dec = '0;
      e_stall = '0;
`endif
      n_checks++;
      if (stat_decoded !== e_dec)
         $display("FAIL %s_decoded: got %0d exp %0d", name, stat_decoded, e_dec);
      else n_pass++;
      n_checks++;
      if (stat_stall !== e_stall)
         $display("FAIL %s_stall: got %0d exp %0d", name, stat_stall, e_stall);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      n_checks++;
      if (bus.in_busy !== 1'b1) $display("FAIL rst_busy: got %b exp 1", bus.in_busy);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (halted !== 1'b0) $display("FAIL rst_halted: got %b exp 0", halted);
      else n_pass++;
      n_checks++;
      if ({bus.out_pc, bus.out_opcode, bus.out_imm, bus.out_exec_mask} !== '0)
         $display("FAIL rst_data: got pc %h op %h imm %h", bus.out_pc, bus.out_opcode, bus.out_imm);
      else n_pass++;
      n_checks++;
      if (stat_decoded !== 32'd0 || stat_stall !== 32'd0)
         $display("FAIL rst_stats: got %0d/%0d exp 0/0", stat_decoded, stat_stall);
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if (bus.in_busy !== 1'b0) $display("FAIL rst_busy_release: got %b exp 0", bus.in_busy);
      else n_pass++;
   endtask

   task automatic test_single();
      bus.out_ready    = 1'b1;
      bus.in_valid     = 1'b1;
      bus.in_pc        = 64'h40;
      bus.in_exec_mask = {$urandom(), $urandom()};
      bus.in_insn      = 32'hFFFC_2A01;
      step();
      idle();
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL single_valid: got %b exp 1", bus.out_valid);
      else n_pass++;
      n_checks++;
      if ({bus.out_opcode, bus.out_dst, bus.out_src1, bus.out_src2} !== {8'h01, 5'h0A, 5'h01, 5'h1F})
         $display("FAIL single_fields: got op %h dst %h s1 %h s2 %h exp 01 0a 01 1f",
                  bus.out_opcode, bus.out_dst, bus.out_src1, bus.out_src2);
      else n_pass++;
      n_checks++;
      if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF)
         $display("FAIL single_imm: got %h exp ffffffffffffffff", bus.out_imm);
      else n_pass++;
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL single_drain: got %b exp 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic accepted8;
      bus.out_ready = 1'b0;
      drive_pkt(64'h0, 8'($urandom_range(1, 8'h30)));
      step();
      drive_pkt(64'h4, 8'($urandom_range(1, 8'h30)));
      step();
      n_checks++;
      if (bus.in_busy !== 1'b1) $display("FAIL bp_busy_full: got %b exp 1", bus.in_busy);
      else n_pass++;
      drive_pkt(64'h8, 8'($urandom_range(1, 8'h30)));
      step();
      step();
      n_checks++;
      if (bus.in_busy !== 1'b1 || bus.out_pc !== 64'h0)
         $display("FAIL bp_hold: got busy %b head pc %h exp 1 0", bus.in_busy, bus.out_pc);
      else n_pass++;
      bus.out_ready = 1'b1;
      accepted8 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.in_valid && !bus.in_busy) accepted8 = 1'b1;
         step();
         if (accepted8) idle();
         if (accepted8 && !bus.out_valid) break;
      end
      n_checks++;
      if (accepted8 !== 1'b1 || bus.out_valid !== 1'b0 || exp_q.size() != 0)
         $display("FAIL bp_drain: got accepted %b valid %b pending %0d exp 1 0 0",
                  accepted8, bus.out_valid, exp_q.size());
      else n_pass++;
`ifdef DECODE_STATS_EN
      n_checks++;
      if (stat_stall < 32'd1) $display("FAIL bp_stall_min: got %0d exp >=1", stat_stall);
      else n_pass++;
`endif
      check_stats("bp");
   endtask

   task automatic test_classify();
      logic [7:0] ops[6] = '{8'h10, 8'h16, 8'h20, 8'h31, 8'h17, 8'h30};
      logic       cf[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       ill[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_pkt(64'h100 + 64'(i * 4), ops[i]);
         step();
         idle();
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_is_cf !== cf[i] || bus.out_illegal !== ill[i])
            $display("FAIL class_%h: got valid %b cf %b ill %b exp 1 %b %b",
                     ops[i], bus.out_valid, bus.out_is_cf, bus.out_illegal, cf[i], ill[i]);
         else n_pass++;
         step();
      end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive_pkt(64'h200, 8'h05);
      step();
      drive_pkt(64'h204, 8'h06);
      step();
      drive_pkt(64'h208, 8'h07);
      bus.out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_busy !== 1'b0)
         $display("FAIL flush_full: got valid %b busy %b exp 0 0", bus.out_valid, bus.in_busy);
      else n_pass++;
      check_stats("flush_full");
      bus.out_ready = 1'b0;
      drive_pkt(64'h300, 8'h02);
      step();
      drive_pkt(64'h304, 8'h03);
      bus.out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_push: got valid %b exp 0", bus.out_valid);
      else n_pass++;
      check_stats("flush_push");
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_stay_empty: got valid %b exp 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_halt();
      bus.out_ready = 1'b1;
      drive_pkt(64'h4, 8'h00);
      step();
      drive_pkt(64'h8, 8'h01);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_opcode !== 8'h00 || bus.out_is_cf !== 1'b1)
         $display("FAIL halt_emit: got valid %b op %h cf %b exp 1 00 1",
                  bus.out_valid, bus.out_opcode, bus.out_is_cf);
      else n_pass++;
      n_checks++;
      if (halted !== 1'b1 || bus.in_busy !== 1'b1)
         $display("FAIL halt_state: got halted %b busy %b exp 1 1", halted, bus.in_busy);
      else n_pass++;
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if (bus.in_busy !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL halt_block: got busy %b valid %b exp 1 0", bus.in_busy, bus.out_valid);
      else n_pass++;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      n_checks++;
      if (halted !== 1'b1 || bus.in_busy !== 1'b1)
         $display("FAIL halt_flush: got halted %b busy %b exp 1 1", halted, bus.in_busy);
      else n_pass++;
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      n_checks++;
      if (halted !== 1'b0 || bus.in_busy !== 1'b0)
         $display("FAIL halt_rst: got halted %b busy %b exp 0 0", halted, bus.in_busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      drive_pkt(64'h400, 8'h0A);
      step();
      drive_pkt(64'h404, 8'h0B);
      step();
      idle();
      n_checks++;
      if (bus.in_busy !== 1'b1 || bus.out_valid !== 1'b1)
         $display("FAIL mid_full: got busy %b valid %b exp 1 1", bus.in_busy, bus.out_valid);
      else n_pass++;
      step();
      check_stats("mid_pre");
      rst = 1'b1;
      step();
      n_checks++;
      if (bus.in_busy !== 1'b1 || bus.out_valid !== 1'b0 || stat_decoded !== 32'd0 || stat_stall !== 32'd0)
         $display("FAIL mid_rst: got busy %b valid %b stats %0d/%0d exp 1 0 0/0",
                  bus.in_busy, bus.out_valid, stat_decoded, stat_stall);
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if (bus.in_busy !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL mid_release: got busy %b valid %b exp 0 0", bus.in_busy, bus.out_valid);
      else n_pass++;
   endtask

   initial begin
      bus.in_valid     = 1'b0;
      bus.in_pc        = '0;
      bus.in_exec_mask = '0;
      bus.in_insn      = '0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_classify();
      test_flush();
      test_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
